// File: rtl/serial_add64.sv
// Digit-serial adder: sums a + b + cin DIGIT bits per clock, LSB digit first,
// and commits sum/cout/OF together on the final digit behind start/busy/done.
module serial_add64 #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] sum,
    output logic                    cout,
    output logic                    OF
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             of_reg;
    logic             done_reg;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] merged;
    logic             last_digit;

    // Select the current digit of each operand with a one-hot compare mux.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_reg == CW'(i)) begin
                a_dig = a_reg[i*DIGIT +: DIGIT];
                b_dig = b_reg[i*DIGIT +: DIGIT];
            end
        end
    end

    assign dsum       = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT+1)'(carry_reg);
    assign last_digit = (cnt_reg == CW'(N - 1));

    // Shadow register with the digit being computed this cycle merged in.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_merge
            assign merged[gi*DIGIT +: DIGIT] = (cnt_reg == CW'(gi)) ? dsum[DIGIT-1:0]
                                                                     : shadow_reg[gi*DIGIT +: DIGIT];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            carry_reg  <= 1'b0;
            shadow_reg <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
            of_reg     <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        carry_reg  <= cin;
                        cnt_reg    <= '0;
                        shadow_reg <= '0;
                        state_reg  <= RUN;
                    end
                end
                default: begin
                    shadow_reg <= merged;
                    carry_reg  <= dsum[DIGIT];
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (last_digit) begin
                        // Overflow uses the latched operand signs, not the live inputs.
                        sum_reg   <= merged;
                        cout_reg  <= dsum[DIGIT];
                        of_reg    <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (merged[WIDTH-1] != a_reg[WIDTH-1]);
                        done_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign OF   = of_reg;

endmodule

// File: doc/serial_add64.md
# serial_add64

Multi-cycle signed adder for the Y86-64 ALU datapath. It computes `a + b + cin` over `DIGIT` bits per clock, least-significant digit first, with a registered carry between digits. It reports the sum, carry-out and two's-complement overflow behind a start/busy/done handshake. It is the adding side of the subtract path: a difference is recovered or checked by adding back, and a subtraction is done by presenting `~y` with `cin=1`. It trades latency for a short carry chain on timing-critical builds.

## Interface
- `WIDTH`, default 64: operand and result width in bits.
- `DIGIT`, default 8: bits added per cycle. `WIDTH % DIGIT == 0` and `1 <= DIGIT <= WIDTH` are required. `DIGIT = WIDTH` gives a single-digit operation.

- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request. Sampled only in IDLE.
- `a`, input, WIDTH (signed): first operand. Captured on the accepting edge.
- `b`, input, WIDTH (signed): second operand. Captured on the accepting edge.
- `cin`, input, 1: carry into bit 0. Captured on the accepting edge.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse when the result is committed.
- `sum`, output, WIDTH (signed): result. Holds until the next completion.
- `cout`, output, 1: carry out of bit WIDTH-1.
- `OF`, output, 1: signed overflow. Set when `a` and `b` have equal sign and `sum` has the opposite sign.

## Operation
- States are IDLE and RUN. The digit counter `cnt` is `ceil(log2(WIDTH/DIGIT))` bits wide, minimum 1.
- IDLE:
  - When `start=1`, latch `a`, `b` and `cin` into operand registers and the carry register. Clear `cnt` and any partial-sum shadow register. Go to RUN.
  - When `start=0`, stay in IDLE.
- RUN, every edge:
  - Add digit `cnt` of both operands plus the carry register.
  - Write the DIGIT-bit result into the shadow register at bits `[cnt*DIGIT +: DIGIT]`.
  - Update the carry register and increment `cnt`.
- Last digit (`cnt == WIDTH/DIGIT - 1`), on the same edge:
  - Copy the shadow register with the final digit merged into `sum`.
  - Set `cout` to the final carry.
  - Compute `OF` from the latched operand sign bits and the new `sum[WIDTH-1]`.
  - Assert `done` for one cycle and return to IDLE.
- `start` during RUN is ignored: no queueing, and in-flight operands are unaffected.
- Input operands may change freely after the accepting edge.
- `sum`, `cout` and `OF` change only on a completion edge. Partial results are never visible.
- All arithmetic is modulo 2^WIDTH. `cout` and `OF` are independent flags.
- Asynchronous reset assertion clears all of the following immediately, at any point including mid-RUN: state to IDLE, `busy`, `done`, `sum`, `cout`, `OF`, `cnt`, carry, operand and shadow registers. An operation interrupted by reset never produces `done`.

## Timing
- Reset values: `busy=0`, `done=0`, `sum=0`, `cout=0`, `OF=0`.
- The accepting edge is E0. `busy` is high from after E0 through after E(N-1), where N = WIDTH/DIGIT.
- `done` and the new results appear after edge EN. `done` is high for exactly one cycle. Default latency is 8 cycles.
- Back-to-back operation: `start=1` during the `done` cycle is accepted at that edge, since the state is IDLE. Throughput is one result per N+1 cycles without gaps.
- `rst_n` deasserts synchronously to `clk` outside the block. The first `start` may be accepted on the first rising edge with `rst_n=1`.
- No combinational path exists from any input to any output.

## Test plan
- Basic add: `a=5`, `b=3`, `cin=0`, `start` pulsed.
  - Expect `busy` for 8 cycles, then `done`, with `sum=8`, `cout=0`, `OF=0`.
  - `sum` stays at 0 until `done`.
- Positive overflow: `a=0x7FFF_FFFF_FFFF_FFFF`, `b=1`.
  - Expect `sum=0x8000_0000_0000_0000`, `OF=1`, `cout=0`.
- Carry across all digits: `a=0xFFFF_FFFF_FFFF_FFFF`, `b=1`, `cin=0`.
  - Expect `sum=0`, `cout=1`, `OF=0`.
- Subtract via add: `a=10`, `b=~64'd3`, `cin=1`.
  - Expect `sum=7`, `cout=1`, `OF=0`.
  - Also `a=0x8000_0000_0000_0000`, `b=~64'd1`, `cin=1`: expect `sum=0x7FFF_FFFF_FFFF_FFFF`, `OF=1`.
- Handshake:
  - Start an op with `a=1`, `b=2`.
  - Pulse `start` with `a=100`, `b=200` at cycle 3 of RUN. Expect it ignored and `sum=3`.
  - Then hold `start` high in the `done` cycle with `a=100`, `b=200`. Expect immediate acceptance and `sum=300` after 8 more cycles.
- Reset mid-operation: drive `rst_n=0` at cycle 4 of RUN.
  - Expect `busy`, `done`, `sum`, `cout` and `OF` at 0 immediately, without waiting for a clock edge.
  - After release, no `done` until a new `start`.
  - Repeat with `DIGIT=64` and `DIGIT=1` to check latencies of 1 and 64 cycles.
